// File: rtl/evt_ts_pkg.sv
// -----------------------------------------------------------------------------
// evt_ts_pkg
// Shared definitions for the event timestamper: default widths, the output
// record layout and the bit positions within the record flags field.
// No ports (package).
// -----------------------------------------------------------------------------
package evt_ts_pkg;

    localparam int unsigned EVT_ID_W = 3;
    localparam int unsigned EVT_TS_W = 8;
    localparam int unsigned FLAGS_W  = 2;

    // Bit positions within the record flags field
    localparam int unsigned FLG_ORPHAN  = 0;
    localparam int unsigned FLG_TIMEOUT = 1;

    // Output record at the default widths, field order matches the FIFO word
    typedef struct packed {
        logic [EVT_ID_W-1:0] id;
        logic [EVT_TS_W-1:0] start_ts;
        logic [EVT_TS_W-1:0] end_ts;
        logic [EVT_TS_W-1:0] delta;
        logic [FLAGS_W-1:0]  flags;
    } evt_rec_t;

endpackage

// File: rtl/evt_sync_fifo.sv
// -----------------------------------------------------------------------------
// evt_sync_fifo
// Single-clock FIFO with valid/ready on both sides and an occupancy count.
// in_ready is derived from the registered occupancy only, so a pop in the same
// cycle never opens space for a push into a full FIFO.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   push handshake, in_data pushed on valid&ready
//   out_valid/out_ready pop handshake, out_data is the head entry
//   count               current occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module evt_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while counted
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: rtl/event_timestamper_v2.sv
// -----------------------------------------------------------------------------
// event_timestamper_v2
// Pairs START/END events by ID and stamps both from a free-running counter.
// Completed (or orphan / timed-out) records are queued in an output FIFO.
// Optional build macro: EVT_TIMEOUT_EN enables a per-ID timeout sweep that
// closes IDs left open for TIMEOUT_CYC cycles or more.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start_valid/ready, start_id    START event handshake
//   end_valid/ready, end_id        END event handshake
//   out_valid/ready                record handshake (FIFO head)
//   out_id, out_start_ts,
//   out_end_ts, out_ts, out_flags  record fields; out_ts = end - start (mod)
//   dup_start                      pulse: START landed on an already-open ID
//   fifo_count                     output FIFO occupancy
// -----------------------------------------------------------------------------
module event_timestamper_v2
    import evt_ts_pkg::*;
#(
    parameter int unsigned ID_W        = EVT_ID_W,
    parameter int unsigned TS_W        = EVT_TS_W,
    parameter int unsigned OUT_DEPTH   = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic [ID_W-1:0]              start_id,
    input  logic                         end_valid,
    output logic                         end_ready,
    input  logic [ID_W-1:0]              end_id,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ID_W-1:0]              out_id,
    output logic [TS_W-1:0]              out_start_ts,
    output logic [TS_W-1:0]              out_end_ts,
    output logic [TS_W-1:0]              out_ts,
    output logic [1:0]                   out_flags,
    output logic                         dup_start,
    output logic [$clog2(OUT_DEPTH):0]   fifo_count
);

    localparam int unsigned N_ID  = 1 << ID_W;
    localparam int unsigned REC_W = ID_W + 3 * TS_W + FLAGS_W;

    if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("OUT_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYC >= (1 << TS_W)) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be below 2**TS_W");
    end

    logic [TS_W-1:0]    cnt_q;
    logic               run_q;
    logic [N_ID-1:0]    active_q;
    logic [N_ID-1:0]    active_d;
    logic [TS_W-1:0]    ts_ram_q [N_ID];
    logic               dup_start_q;

    logic               collision;
    logic               start_hs;
    logic               end_hs;

    logic               push_valid;
    logic [ID_W-1:0]    push_id;
    logic [TS_W-1:0]    push_start;
    logic [TS_W-1:0]    push_end;
    logic [TS_W-1:0]    push_delta;
    logic [FLAGS_W-1:0] push_flags;

    logic               fifo_in_ready;
    logic               fifo_out_valid;
    logic [REC_W-1:0]   fifo_out_data;

    // Same-ID collision: END is served first, START retries next cycle
    assign collision   = start_valid & end_valid & (start_id == end_id);
    // run_q keeps both readies low until the first edge after reset release
    assign start_ready = run_q & ~collision;
    assign end_ready   = run_q & fifo_in_ready;
    assign start_hs    = start_valid & start_ready;
    assign end_hs      = end_valid & end_ready;

`ifdef EVT_TIMEOUT_EN
    localparam logic [TS_W-1:0] TO_LIM = TS_W'(TIMEOUT_CYC);

    logic [ID_W-1:0] ptr_q;
    logic [TS_W-1:0] sweep_age;
    logic            sweep_stall;
    logic            sweep_fire;

    assign sweep_age   = cnt_q - ts_ram_q[ptr_q];
    // Hold the pointer whenever the FIFO slot or the visited ID is contended
    assign sweep_stall = end_hs | ~fifo_in_ready | (start_hs & (start_id == ptr_q));
    assign sweep_fire  = ~sweep_stall & active_q[ptr_q] & (sweep_age >= TO_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (!sweep_stall) begin
            ptr_q <= ptr_q + ID_W'(1);
        end
    end
`endif

    // Record selection: END handshakes take priority over the sweep
    always_comb begin
        push_valid = 1'b0;
        push_id    = '0;
        push_start = cnt_q;
        push_end   = cnt_q;
        push_flags = '0;
        if (end_hs) begin
            push_valid = 1'b1;
            push_id    = end_id;
            if (active_q[end_id]) begin
                push_start = ts_ram_q[end_id];
            end else begin
                push_flags[FLG_ORPHAN] = 1'b1;
            end
        end
`ifdef EVT_TIMEOUT_EN
        else if (sweep_fire) begin
            push_valid              = 1'b1;
            push_id                 = ptr_q;
            push_start              = ts_ram_q[ptr_q];
            push_flags[FLG_TIMEOUT] = 1'b1;
        end
`endif
    end

    assign push_delta = push_end - push_start;

    always_comb begin
        active_d = active_q;
        if (end_hs) active_d[end_id] = 1'b0;
`ifdef EVT_TIMEOUT_EN
        if (sweep_fire) active_d[ptr_q] = 1'b0;
`endif
        if (start_hs) active_d[start_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            run_q       <= 1'b0;
            active_q    <= '0;
            dup_start_q <= 1'b0;
            for (int i = 0; i < int'(N_ID); i++) begin
                ts_ram_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_q + TS_W'(1);
            run_q       <= 1'b1;
            active_q    <= active_d;
            dup_start_q <= start_hs & active_q[start_id];
            if (start_hs) ts_ram_q[start_id] <= cnt_q;
        end
    end

    evt_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push_valid),
        .in_ready  (fifo_in_ready),
        .in_data   ({push_id, push_start, push_end, push_delta, push_flags}),
        .out_valid (fifo_out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_out_data),
        .count     (fifo_count)
    );

    assign out_valid = fifo_out_valid;
    assign dup_start = dup_start_q;

    // Record fields read as zero while nothing is buffered
    assign {out_id, out_start_ts, out_end_ts, out_ts, out_flags} =
        fifo_out_valid ? fifo_out_data : '0;

endmodule

// File: tb/tb_event_timestamper_v2.sv
// -----------------------------------------------------------------------------
// tb_event_timestamper_v2
// Directed bench: stimulus pushes hand-computed records into a queue, a
// monitor pops and compares every record the DUT hands out.
// -----------------------------------------------------------------------------
module tb_event_timestamper_v2;
    import evt_ts_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    logic [2:0] start_id;
    logic       end_valid;
    logic       end_ready;
    logic [2:0] end_id;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_id;
    logic [7:0] out_start_ts;
    logic [7:0] out_end_ts;
    logic [7:0] out_ts;
    logic [1:0] out_flags;
    logic       dup_start;
    logic [2:0] fifo_count;

    int n_chk  = 0;
    int n_pass = 0;

    evt_rec_t sb[$];
    bit       sb_loose[$];

    // Reference time base: the value the counter holds until the next edge
    logic [7:0] mcnt;

    event_timestamper_v2 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .start_id     (start_id),
        .end_valid    (end_valid),
        .end_ready    (end_ready),
        .end_id       (end_id),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_id       (out_id),
        .out_start_ts (out_start_ts),
        .out_end_ts   (out_end_ts),
        .out_ts       (out_ts),
        .out_flags    (out_flags),
        .dup_start    (dup_start),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcnt <= 8'd0;
        else        mcnt <= mcnt + 8'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    task automatic exp_rec(input int id, input int st, input int en, input int dl,
                           input int fl, input bit loose);
        evt_rec_t r;
        r.id       = 3'(id);
        r.start_ts = 8'(st);
        r.end_ts   = 8'(en);
        r.delta    = 8'(dl);
        r.flags    = 2'(fl);
        sb.push_back(r);
        sb_loose.push_back(loose);
    endtask

    // Monitor: compare each popped record against the queue head
    always @(negedge clk) begin
        evt_rec_t act;
        evt_rec_t req;
        bit       loose;
        bit       ok;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            act = '{out_id, out_start_ts, out_end_ts, out_ts, out_flags};
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL record: actual id=%0d st=%0d en=%0d d=%0d f=%0d required none",
                         act.id, act.start_ts, act.end_ts, act.delta, act.flags);
            end else begin
                req   = sb.pop_front();
                loose = sb_loose.pop_front();
                if (loose) begin
                    ok = act.id == req.id && act.start_ts == req.start_ts &&
                         act.flags == req.flags && act.delta >= 8'd16 &&
                         act.delta <= 8'd24 && act.end_ts == act.start_ts + act.delta;
                end else begin
                    ok = (act == req);
                end
                if (ok) n_pass++;
                else $display("FAIL record: actual id=%0d st=%0d en=%0d d=%0d f=%0d required id=%0d st=%0d en=%0d d=%0d f=%0d",
                              act.id, act.start_ts, act.end_ts, act.delta, act.flags,
                              req.id, req.start_ts, req.end_ts, req.delta, req.flags);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int v);
        int guard = 0;
        while (mcnt != 8'(v) && guard < 300) begin
            tick();
            guard++;
        end
        if (guard >= 300) chk("wait_cnt_timeout", 32'(mcnt), 32'(v));
    endtask

    // Both event tasks start and end 1 time unit after a rising edge
    task automatic start_ev(input int id);
        int guard = 0;
        start_valid = 1'b1;
        start_id    = 3'(id);
        @(negedge clk);
        while (!start_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("start_ready_timeout", 32'(start_ready), 1);
        tick();
        start_valid = 1'b0;
    endtask

    task automatic end_ev(input int id);
        int guard = 0;
        end_valid = 1'b1;
        end_id    = 3'(id);
        @(negedge clk);
        while (!end_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("end_ready_timeout", 32'(end_ready), 1);
        tick();
        end_valid = 1'b0;
    endtask

    initial begin
        int guard;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        start_id    = 3'd0;
        end_valid   = 1'b0;
        end_id      = 3'd0;
        out_ready   = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_start_ready", 32'(start_ready), 0);
        chk("rst_end_ready", 32'(end_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_fifo_count", 32'(fifo_count), 0);
        chk("rst_dup_start", 32'(dup_start), 0);
        chk("rst_record", 32'({out_id, out_start_ts, out_end_ts, out_ts, out_flags}), 0);
        tick();
        rst_n = 1'b1;

        // Basic pair: start id3 @10, end @16
        wait_cnt(10);
        start_ev(3);
        wait_cnt(16);
        exp_rec(3, 10, 16, 6, 0, 1'b0);
        end_ev(3);
        @(negedge clk);
        chk("latency_out_valid", 32'(out_valid), 1);
        tick();

        // Counter wrap: start id1 @250, end @4
        wait_cnt(250);
        start_ev(1);
        wait_cnt(4);
        exp_rec(1, 250, 4, 10, 0, 1'b0);
        end_ev(1);

        // Orphan end and duplicate start
        wait_cnt(20);
        exp_rec(6, 20, 20, 0, 1, 1'b0);
        end_ev(6);
        wait_cnt(30);
        start_ev(2);
        @(negedge clk);
        chk("dup_first_start", 32'(dup_start), 0);
        tick();
        wait_cnt(40);
        start_ev(2);
        @(negedge clk);
        chk("dup_pulse", 32'(dup_start), 1);
        tick();
        @(negedge clk);
        chk("dup_pulse_end", 32'(dup_start), 0);
        tick();
        wait_cnt(45);
        exp_rec(2, 40, 45, 5, 0, 1'b0);
        end_ev(2);

        // Same-ID collision on id5
        wait_cnt(60);
        start_ev(5);
        wait_cnt(70);
        start_valid = 1'b1;
        start_id    = 3'd5;
        end_valid   = 1'b1;
        end_id      = 3'd5;
        exp_rec(5, 60, 70, 10, 0, 1'b0);
        @(negedge clk);
        chk("collision_start_ready", 32'(start_ready), 0);
        chk("collision_end_ready", 32'(end_ready), 1);
        tick();
        end_valid = 1'b0;
        @(negedge clk);
        chk("retry_start_ready", 32'(start_ready), 1);
        tick();
        start_valid = 1'b0;
        @(negedge clk);
        chk("retry_no_dup", 32'(dup_start), 0);
        tick();
        wait_cnt(80);
        exp_rec(5, 71, 80, 9, 0, 1'b0);
        end_ev(5);

        // FIFO fill, backpressure, order, reset mid-burst
        wait_cnt(99);
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) start_ev(i);
        for (int i = 0; i < 4; i++) begin
            exp_rec(i, 100 + i, 105 + i, 5, 0, 1'b0);
            end_ev(i);
        end
        end_valid = 1'b1;
        end_id    = 3'd4;
        @(negedge clk);
        chk("full_count", 32'(fifo_count), 4);
        chk("full_end_ready", 32'(end_ready), 0);
        chk("hold_start_ts_a", 32'(out_start_ts), 100);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_end_ready_2", 32'(end_ready), 0);
        chk("hold_start_ts_b", 32'(out_start_ts), 100);
        chk("hold_end_ts_b", 32'(out_end_ts), 105);
        tick();
        out_ready = 1'b0;
        exp_rec(4, 104, 111, 7, 0, 1'b0);
        @(negedge clk);
        chk("after_pop_end_ready", 32'(end_ready), 1);
        tick();
        end_valid = 1'b0;
        @(negedge clk);
        chk("refill_count", 32'(fifo_count), 4);
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("drain2_count", 32'(fifo_count), 2);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_fifo_count", 32'(fifo_count), 0);
        sb.delete();
        sb_loose.delete();
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Open ID left alone: timeout record only with the sweep built in
        wait_cnt(20);
`ifdef EVT_TIMEOUT_EN
        exp_rec(2, 20, 0, 0, 2, 1'b1);
        start_ev(2);
        wait_cnt(50);
        exp_rec(2, 50, 50, 0, 1, 1'b0);
        end_ev(2);
`else
        start_ev(2);
        wait_cnt(49);
        @(negedge clk);
        chk("no_timeout_out_valid", 32'(out_valid), 0);
        chk("no_timeout_count", 32'(fifo_count), 0);
        tick();
        exp_rec(2, 20, 50, 30, 0, 1'b0);
        end_ev(2);
`endif

        // Drain remaining expectations
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        chk("drain_remaining", 32'(sb.size()), 0);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/event_timestamper_v2.md
Name: event_timestamper_v2

Overview:
Next-generation event timer that pairs start/end events by ID and stamps both from a free-running TS_W-bit counter. Output records are buffered in an OUT_DEPTH FIFO, so downstream backpressure no longer stalls END acceptance after a single record. Adds explicit error flags (orphan end, duplicate start) and an optional per-ID timeout sweep. Sits between event sources (e.g. packet RX/TX taps) and the timestamp reporting path.

Parameters:
ID_W, 3, ID width; 2**ID_W tracked IDs
TS_W, 8, counter/timestamp width
OUT_DEPTH, 4, output FIFO depth (power of 2, >=2)
TIMEOUT_CYC, 16, age in cycles at which an open ID times out (only with TIMEOUT_EN; must be < 2**TS_W)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  start event valid
start_ready  out  1  start accepted when valid&ready
start_id  in  ID_W  start event ID
end_valid  in  1  end event valid
end_ready  out  1  end accepted when valid&ready
end_id  in  ID_W  end event ID
out_valid  out  1  record available (FIFO not empty)
out_ready  in  1  consumer pop
out_id  out  ID_W  record ID
out_start_ts  out  TS_W  start timestamp
out_end_ts  out  TS_W  end/timeout timestamp
out_ts  out  TS_W  delta = end_ts - start_ts mod 2**TS_W
out_flags  out  2  bit0 orphan end, bit1 timeout
dup_start  out  1  one-cycle pulse: start accepted on an already-active ID
fifo_count  out  $clog2(OUT_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, async): cnt_q=0, all active bits 0, FIFO empty, out_valid=0, dup_start=0, fifo_count=0, start_ready=0, end_ready=0; record outputs 0. Reset mid-operation discards all open IDs and buffered records.
- cnt_q increments every cycle, wraps 2**TS_W-1 -> 0. Timestamps capture the cnt_q value present at the handshake edge.
- START handshake: ts_ram[id]<=cnt_q, active[id]<=1. If already active: overwrite ts, dup_start=1 next cycle.
- END handshake: push {id, ts_ram[id], cnt_q, delta, flags=00}, clear active[id]. If ID not active: push orphan record start_ts=end_ts=cnt_q, delta=0, flags=01.
- end_ready = !fifo_full (registered occupancy). start_ready = 1 except same-cycle collision.
- Collision (start_valid & end_valid & start_id==end_id): END wins; start_ready=0 that cycle; START retried next cycle and stamped then.
- Start and end on different IDs in the same cycle: both accepted.
- Latency: record visible on out_valid the cycle after END handshake when FIFO was empty. Pop on out_valid&out_ready; outputs stable while out_valid&!out_ready.
- Simultaneous push and pop when full: pop occurs, push blocked (end_ready already 0). FIFO preserves END order.
- Delta is modular: correct only for intervals < 2**TS_W cycles.

Optional Feature:
EVT_TIMEOUT_EN. Defined: sweep pointer visits one ID per cycle; if active and (cnt_q - ts_ram[ptr]) mod 2**TS_W >= TIMEOUT_CYC, push {ptr, ts, cnt_q, delta, flags=10} and clear active. Sweep stalls (pointer holds) when an END handshake occurs that cycle, FIFO full, or ptr equals the start or end ID handshaking that cycle. A later END on a timed-out ID yields an orphan record. Undefined: no sweep logic; out_flags[1] tied 0; TIMEOUT_CYC unused.

Decomposition:
- Package evt_ts_pkg: record struct (id, start_ts, end_ts, delta, flags) parametrised via localparam widths; flag bit index constants FLG_ORPHAN=0, FLG_TIMEOUT=1.
- Sub-module evt_sync_fifo: single-clock FIFO, WIDTH/DEPTH params, valid/ready on both sides, count output, async active-low reset.

Test Plan:
1. ID_W=3,TS_W=8: start id3 at cnt=10, end id3 at cnt=16, out_ready=1 -> one record id3, start=10, end=16, delta=6, flags=00, out_valid the cycle after END.
2. Wrap: start id1 at cnt=250, end id1 at cnt=4 -> delta=10, flags=00.
3. out_ready=0, start then end IDs 0..4 -> four records buffered, fifo_count=4, end_ready=0 on fifth until one pop; records pop in END order. Assert rst_n mid-burst -> out_valid=0, fifo_count=0 immediately.
4. Collision: id5 active, start&end id5 same cycle -> END record emitted, start_ready=0 that cycle, START accepted next cycle with that cycle's cnt_q; later END id5 uses new ts.
5. END id6 never started -> flags=01, start_ts=end_ts, delta=0. Start id2 twice (cnt=30, 40), end at 45 -> dup_start pulse once, delta=5.
6. With EVT_TIMEOUT_EN, TIMEOUT_CYC=16: start id2 at cnt=20, no end -> timeout record id2 within 16+8 cycles, delta>=16, flags=10; subsequent END id2 -> orphan. Without macro -> no record generated.
